// File: rtl/reconstruct_audio.sv
// 2x audio upsampler: buffers 24 kHz samples in a small FIFO and emits a
// linearly interpolated 48 kHz stream, one output per audio_trigger tick.
module reconstruct_audio #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                              audio_clk,
  input  logic                              rst_in,
  input  logic                              audio_trigger,
  input  logic                              sample_valid_in,
  input  logic signed [15:0]                sample_in,
  output logic signed [15:0]                audio_out,
  output logic                              audio_out_valid,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_count,
  output logic                              underflow,
  output logic                              overflow
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    PRIME = 2'd0,
    MID   = 2'd1,
    EVEN  = 2'd2
  } state_t;

  state_t                   state;
  logic signed [15:0]       cur;
  logic signed [15:0]       mem [FIFO_DEPTH];
  logic [PW-1:0]            wr_ptr;
  logic [PW-1:0]            rd_ptr;

  logic signed [15:0]       head_c;
  logic signed [16:0]       sum_c;
  logic                     pop_c;
  logic                     full_c;
  logic                     wr_c;

  // Decisions use only the registered count, so a same-cycle write is invisible.
  always_comb begin
    head_c = mem[rd_ptr];
    sum_c  = $signed({cur[15], cur}) + $signed({head_c[15], head_c});
    full_c = (fifo_count == CW'(FIFO_DEPTH));
    pop_c  = 1'b0;
    if (audio_trigger) begin
      unique case (state)
        PRIME:   pop_c = (fifo_count >= CW'(2));
        EVEN:    pop_c = (fifo_count != CW'(0));
        default: pop_c = 1'b0;
      endcase
    end
    wr_c = sample_valid_in && (!full_c || pop_c);
  end

  always_ff @(posedge audio_clk) begin
    if (rst_in) begin
      state           <= PRIME;
      cur             <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      fifo_count      <= '0;
      audio_out       <= '0;
      audio_out_valid <= 1'b0;
      underflow       <= 1'b0;
      overflow        <= 1'b0;
    end else begin
      audio_out_valid <= audio_trigger;

      if (wr_c) begin
        mem[wr_ptr] <= sample_in;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (sample_valid_in && !wr_c) begin
        overflow <= 1'b1;
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (wr_c && !pop_c) begin
        fifo_count <= fifo_count + CW'(1);
      end else if (pop_c && !wr_c) begin
        fifo_count <= fifo_count - CW'(1);
      end

      // Output sequencer: pop on PRIME/EVEN, interpolate on MID.
      if (audio_trigger) begin
        unique case (state)
          PRIME: begin
            if (pop_c) begin
              cur       <= head_c;
              audio_out <= head_c;
              state     <= MID;
            end
          end
          MID: begin
            if (fifo_count != CW'(0)) begin
              audio_out <= sum_c[16:1];
              state     <= EVEN;
            end else begin
              audio_out <= cur;
              underflow <= 1'b1;
              state     <= PRIME;
            end
          end
          EVEN: begin
            cur       <= head_c;
            audio_out <= head_c;
            state     <= MID;
          end
          default: state <= PRIME;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reconstruct_audio.sv
// Scoreboard bench for reconstruct_audio: a queue-based reference model predicts
// each output; a monitor compares outputs and status every cycle.
module tb_reconstruct_audio;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 trig = 1'b0;
  logic                 vld = 1'b0;
  logic signed [15:0]   din = '0;
  logic signed [15:0]   dout;
  logic                 dout_vld;
  logic [CW-1:0]        cnt;
  logic                 uf;
  logic                 of;

  reconstruct_audio #(.FIFO_DEPTH(DEPTH)) dut (
    .audio_clk       (clk),
    .rst_in          (rst),
    .audio_trigger   (trig),
    .sample_valid_in (vld),
    .sample_in       (din),
    .audio_out       (dout),
    .audio_out_valid (dout_vld),
    .fifo_count      (cnt),
    .underflow       (uf),
    .overflow        (of)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 = waiting to prime, 1 = halfway point next, 2 = new sample next
  int m_fifo[$];
  int m_phase;
  int m_cur;
  int m_last;
  bit m_uf;
  bit m_of;
  bit exp_vld;
  int exp_q[$];

  int checks = 0;
  int errors = 0;
  bit done = 1'b0;

  function automatic int floor_half(input int s);
    if (s < 0 && (s % 2) != 0) return s / 2 - 1;
    return s / 2;
  endfunction

  function automatic void model_reset();
    m_fifo.delete();
    m_phase = 0;
    m_cur   = 0;
    m_last  = 0;
    m_uf    = 1'b0;
    m_of    = 1'b0;
  endfunction

  // Apply one cycle of stimulus; model is advanced to its post-edge state.
  task automatic step(input bit r, input bit t, input bit v, input int d);
    bit popped;
    int out;
    rst  = r;
    trig = t;
    vld  = v;
    din  = 16'(d);
    popped  = 1'b0;
    exp_vld = 1'b0;
    if (r) begin
      model_reset();
    end else begin
      if (t) begin
        out = m_last;
        if (m_phase == 0) begin
          if (m_fifo.size() >= 2) begin
            m_cur = m_fifo.pop_front(); out = m_cur; popped = 1'b1; m_phase = 1;
          end
        end else if (m_phase == 1) begin
          if (m_fifo.size() >= 1) begin
            out = floor_half(m_cur + m_fifo[0]); m_phase = 2;
          end else begin
            out = m_cur; m_uf = 1'b1; m_phase = 0;
          end
        end else begin
          m_cur = m_fifo.pop_front(); out = m_cur; popped = 1'b1; m_phase = 1;
        end
        m_last  = out;
        exp_vld = 1'b1;
        exp_q.push_back(out);
      end
      if (v) begin
        if (m_fifo.size() + (popped ? 1 : 0) <= DEPTH - 1 + (popped ? 1 : 0) &&
            (m_fifo.size() < DEPTH || popped)) m_fifo.push_back(d);
        else m_of = 1'b1;
      end
    end
    @(posedge clk);
    #2;
    rst = 1'b0; trig = 1'b0; vld = 1'b0;
  endtask

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compares every cycle after the active edge.
  initial begin
    int e;
    forever begin
      @(posedge clk);
      #1;
      if (done) break;
      check("valid", int'(dout_vld), int'(exp_vld));
      if (dout_vld) begin
        if (exp_q.size() == 0) begin
          errors++; checks++;
          $display("FAIL unexpected_out: got %0d expected none", dout);
        end else begin
          e = exp_q.pop_front();
          check("audio_out", int'(dout), e);
        end
      end
      check("fifo_count", int'(cnt), m_fifo.size());
      check("underflow", int'(uf), int'(m_uf));
      check("overflow", int'(of), int'(m_of));
    end
  end

  task automatic wr(input int d);  step(0, 0, 1, d); endtask
  task automatic tg();             step(0, 1, 0, 0); endtask
  task automatic rs();             step(1, 0, 0, 0); endtask

  initial begin
    model_reset();
    exp_vld = 1'b0;
    #2;
    rs(); rs();
    check("reset_out", int'(dout), 0);

    // Priming and starvation
    wr(100); wr(200); tg(); tg(); tg(); tg();
    check("prime_hold", int'(dout), 200);
    check("prime_uf", int'(uf), 1);

    // Steady state, interleaved
    rs();
    wr(0); wr(1000); tg(); tg(); wr(-1000); tg(); tg(); wr(2000); tg(); tg(); tg();
    check("steady_last", int'(dout), 2000);

    // Rounding and saturation-free extremes
    rs(); wr(-3); wr(0); tg(); tg();
    check("round_neg", int'(dout), -2);
    rs(); wr(32767); wr(32767); tg(); tg();
    check("max_avg", int'(dout), 32767);
    rs(); wr(-32768); wr(-32768); tg(); tg();
    check("min_avg", int'(dout), -32768);

    // Overflow: fifth sample dropped
    rs();
    for (int i = 1; i <= 5; i++) wr(i * 11);
    check("ovf_count", int'(cnt), 4);
    check("ovf_flag", int'(of), 1);
    for (int i = 0; i < 10; i++) tg();

    // Simultaneous write + trigger with count 1 in PRIME
    rs(); wr(7); step(0, 1, 1, 9);
    check("simul_hold", int'(dout), 0);
    tg();
    check("simul_pop", int'(dout), 7);

    // Reset in MID with count 3
    rs(); wr(1); wr(2); wr(3); wr(4); tg();
    check("mid_count", int'(cnt), 3);
    rs();
    check("rst_count", int'(cnt), 0);
    tg();
    check("rst_out", int'(dout), 0);

    // Randomized traffic
    rs();
    for (int i = 0; i < 3000; i++) begin
      automatic bit t = ($urandom_range(0, 99) < 50);
      automatic bit v = ($urandom_range(0, 99) < 27);
      automatic bit r = ($urandom_range(0, 999) == 0);
      step(r, t, v, int'($signed(16'($urandom))));
    end
    step(0, 0, 0, 0);

    done = 1'b1;
    @(posedge clk); #2;
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
